mm_traffic_gen: RTL and testbench
=================================

// Module: mm_traffic_gen
// PURPOSE
//  AXI4 memory-mapped master traffic generator downstream of the MM CSR block.
//  Consumes the single-cycle aximm_wr/aximm_rd start pulses and their length/burst/size/address.
//  Issues one AXI4 write burst (AW, W, B) or read burst (AR, R) per start.
//  Writes a deterministic data pattern; checks read data against the same pattern.
//  Returns write_complete/read_complete, chkr_pass and first/last beat captures to the CSR block.
// PARAMETERS
//  DATA_W        64            AXI data width (64 or 128; AXI_CHNL_NUM*64)
//  PATTERN_SEED  32'hA5A5_0000 base of 32-bit pattern words
// PORTS
//  clk                  in   1       clock
//  rst_n                in   1       asynchronous, active-low reset
//  i_wr_start           in   1       write start pulse (aximm_wr)
//  i_rd_start           in   1       read start pulse (aximm_rd)
//  i_len/i_burst/i_size in   8/2/3   AXI len/burst/size, sampled on start
//  i_addr               in   32      burst start address, sampled on start
//  m_aw{addr,len,size,burst} out 32/8/3/2; m_awvalid out 1; m_awready in 1
//  m_wdata out DATA_W; m_wstrb out DATA_W/8; m_wlast out 1; m_wvalid out 1; m_wready in 1
//  m_bresp in 2; m_bvalid in 1; m_bready out 1
//  m_ar{addr,len,size,burst} out 32/8/3/2; m_arvalid out 1; m_arready in 1
//  m_rdata in DATA_W; m_rresp in 2; m_rlast in 1; m_rvalid in 1; m_rready out 1
//  write_complete/read_complete out 1 each  level, burst done
//  chkr_pass            out  2       [1]=read check done, [0]=pass
//  data_out_first/last  out  DATA_W  first/last written beat; *_valid out 1, 1-cycle pulse
//  data_in_first/last   out  DATA_W  first/last read beat; *_valid out 1, 1-cycle pulse
//  o_busy               out  1       FSM not IDLE
// BEHAVIOUR
//  Reset: every output 0; FSM to IDLE. Reset mid-burst drops all valids immediately; no
//   completion reported. Async assert, sync deassert via the design's reset synchroniser.
//  FSM: IDLE -> WR_AW -> WR_DATA -> WR_RESP -> IDLE; IDLE -> RD_AR -> RD_DATA -> IDLE.
//  IDLE: i_wr_start -> latch cmd, clear write_complete, go WR_AW.
//   i_rd_start -> latch cmd, clear read_complete and chkr_pass, go RD_AR.
//   Both asserted together: write wins; read dropped.
//   Starts outside IDLE are ignored.
//  WR_AW: awvalid=1 with latched fields until awready; then WR_DATA. W never precedes the AW handshake.
//  WR_DATA: beats k=0..len; wvalid held, data stable until wready; wstrb all ones.
//   wlast=1 only on k==len. data_out_first_valid pulses on k=0 handshake; data_out_last_valid on k=len.
//  WR_RESP: bready=1; on bvalid: write_complete=1 (any bresp); then IDLE.
//  RD_AR: arvalid=1 until arready; then RD_DATA.
//  RD_DATA: rready=1. Each beat compared with the pattern for beat k; mismatch, rresp!=OKAY, or
//   rlast on k!=len sets the error flag. The burst ends on the rlast beat, or on beat len if rlast
//   is missing (error). At end: read_complete=1, chkr_pass={1'b1,~err}; then IDLE.
//   data_in_first/last captured as for write.
//  Pattern: 32-bit word j of beat k = PATTERN_SEED + k*(DATA_W/32) + j, mod 2^32.
//   The beat counter is 8 bits; len=255 gives 256 beats with no wrap error.
//  i_burst/i_size/i_addr pass through unmodified; the pattern does not depend on burst type.
//  len=0: single beat; first and last valid pulse in the same cycle.
//  chkr_pass[1] rises exactly once per read; the CSR block edge-detects it.
// STRUCTURE
//  Package mm_tg_pkg: FSM state enum, AXI_RESP_OKAY=2'b00, BURST_* codes, pattern function.
//  Sub-module mm_tg_pattern: beat index -> DATA_W pattern. Shared by the W path and the R checker.
// TESTING
//  Write len=3, INCR, addr 0x100, ready always 1 -> 4 W beats; wlast on 4th;
//   data_out_first word0 = 0xA5A50000; write_complete=1 after B.
//  Read of the same burst with correct data -> read_complete=1, chkr_pass=2'b11;
//   data_in_last word0 = 0xA5A50006 (DATA_W=64).
//  Read with beat 2 corrupted, or rresp=SLVERR -> chkr_pass=2'b10.
//  Random wready/rready stall (50%) on len=255 -> 256 beats, no data change while stalled, pass.
//  Simultaneous wr/rd start -> only AW issued; arvalid stays 0.
//   A start while busy -> ignored.
//  rst_n asserted in WR_DATA beat 1 -> all valids 0 that cycle, complete flags 0;
//   a new write after release runs clean.

Source files
------------

// File: rtl/mm_tg_pkg.sv
// Shared types and helpers for the AXI4 memory-mapped traffic generator.
// The pattern word function is used by the RTL generator and the read checker alike.
package mm_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_AR,
        ST_RD_DATA
    } tg_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] BURST_FIXED   = 2'b00;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] BURST_WRAP    = 2'b10;

    function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                                 input logic [7:0]  beat,
                                                 input int          words_per_beat,
                                                 input int          word_idx);
        return seed + 32'(beat) * 32'(words_per_beat) + 32'(word_idx);
    endfunction

endpackage

// File: rtl/mm_tg_pattern.sv
// Beat index to DATA_W-wide data pattern; word j occupies bits [32*j +: 32].
module mm_tg_pattern
    import mm_tg_pkg::*;
#(
    parameter int          DATA_W       = 64,
    parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
    input  logic [7:0]        beat,
    output logic [DATA_W-1:0] pattern
);

    localparam int WORDS = DATA_W / 32;

    for (genvar j = 0; j < WORDS; j++) begin : g_word
        assign pattern[32*j +: 32] = pattern_word(PATTERN_SEED, beat, WORDS, j);
    end

endmodule

// File: rtl/mm_traffic_gen.sv
// AXI4 master traffic generator: one write (AW/W/B) or read (AR/R) burst per start pulse,
// writing a deterministic pattern and checking read data against it.
//
// state      | meaning
// IDLE       | waiting for a start pulse
// WR_AW      | presenting write address until awready
// WR_DATA    | streaming write beats 0..len
// WR_RESP    | waiting for the write response
// RD_AR      | presenting read address until arready
// RD_DATA    | accepting and checking read beats
module mm_traffic_gen
    import mm_tg_pkg::*;
#(
    parameter int          DATA_W       = 64,
    parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_start,
    input  logic                i_rd_start,
    input  logic [7:0]          i_len,
    input  logic [1:0]          i_burst,
    input  logic [2:0]          i_size,
    input  logic [31:0]         i_addr,
    output logic [31:0]         m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [31:0]         m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic                write_complete,
    output logic                read_complete,
    output logic [1:0]          chkr_pass,
    output logic [DATA_W-1:0]   data_out_first,
    output logic                data_out_first_valid,
    output logic [DATA_W-1:0]   data_out_last,
    output logic                data_out_last_valid,
    output logic [DATA_W-1:0]   data_in_first,
    output logic                data_in_first_valid,
    output logic [DATA_W-1:0]   data_in_last,
    output logic                data_in_last_valid,
    output logic                o_busy
);

    tg_state_e         state, state_nxt;
    logic [1:0]        rst_sync;
    logic              rst_int_n;
    logic [7:0]        cmd_len;
    logic [1:0]        cmd_burst;
    logic [2:0]        cmd_size;
    logic [31:0]       cmd_addr;
    logic [7:0]        beat;
    logic              rd_err;
    logic [DATA_W-1:0] pattern;
    logic              last_beat, wr_hs, rd_hs, rd_end, beat_err, rd_err_nxt;
    logic              unused_bresp;

    // Any write response completes the burst, so bresp is observed but not acted on.
    assign unused_bresp = ^m_bresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    mm_tg_pattern #(.DATA_W(DATA_W), .PATTERN_SEED(PATTERN_SEED)) u_pattern (
        .beat    (beat),
        .pattern (pattern)
    );

    assign last_beat  = (beat == cmd_len);
    assign wr_hs      = (state == ST_WR_DATA) && m_wready;
    assign rd_hs      = (state == ST_RD_DATA) && m_rvalid;
    assign rd_end     = m_rlast || last_beat;
    assign beat_err   = (m_rdata != pattern) || (m_rresp != AXI_RESP_OKAY) || (m_rlast != last_beat);
    assign rd_err_nxt = rd_err || beat_err;

    assign m_awaddr  = cmd_addr;
    assign m_awlen   = cmd_len;
    assign m_awsize  = cmd_size;
    assign m_awburst = cmd_burst;
    assign m_araddr  = cmd_addr;
    assign m_arlen   = cmd_len;
    assign m_arsize  = cmd_size;
    assign m_arburst = cmd_burst;
    assign o_busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_wr_start)      state_nxt = ST_WR_AW;
                else if (i_rd_start) state_nxt = ST_RD_AR;
            end
            ST_WR_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) state_nxt = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                m_wvalid = 1'b1;
                m_wdata  = pattern;
                m_wstrb  = '1;
                m_wlast  = last_beat;
                if (m_wready && last_beat) state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_nxt = ST_IDLE;
            end
            ST_RD_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid && rd_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cmd_len              <= '0;
            cmd_burst            <= '0;
            cmd_size             <= '0;
            cmd_addr             <= '0;
            beat                 <= '0;
            rd_err               <= 1'b0;
            write_complete       <= 1'b0;
            read_complete        <= 1'b0;
            chkr_pass            <= 2'b00;
            data_out_first       <= '0;
            data_out_first_valid <= 1'b0;
            data_out_last        <= '0;
            data_out_last_valid  <= 1'b0;
            data_in_first        <= '0;
            data_in_first_valid  <= 1'b0;
            data_in_last         <= '0;
            data_in_last_valid   <= 1'b0;
        end else begin
            data_out_first_valid <= 1'b0;
            data_out_last_valid  <= 1'b0;
            data_in_first_valid  <= 1'b0;
            data_in_last_valid   <= 1'b0;

            if (state == ST_IDLE && (i_wr_start || i_rd_start)) begin
                cmd_len   <= i_len;
                cmd_burst <= i_burst;
                cmd_size  <= i_size;
                cmd_addr  <= i_addr;
                beat      <= '0;
                if (i_wr_start) begin
                    write_complete <= 1'b0;
                end else begin
                    read_complete <= 1'b0;
                    chkr_pass     <= 2'b00;
                    rd_err        <= 1'b0;
                end
            end

            if (wr_hs) begin
                if (beat == 8'd0) begin
                    data_out_first       <= pattern;
                    data_out_first_valid <= 1'b1;
                end
                if (last_beat) begin
                    data_out_last       <= pattern;
                    data_out_last_valid <= 1'b1;
                end else begin
                    beat <= beat + 8'd1;
                end
            end

            if (state == ST_WR_RESP && m_bvalid) write_complete <= 1'b1;

            if (rd_hs) begin
                rd_err <= rd_err_nxt;
                if (beat == 8'd0) begin
                    data_in_first       <= m_rdata;
                    data_in_first_valid <= 1'b1;
                end
                // A missing rlast still ends the burst on beat len, flagged via beat_err.
                if (rd_end) begin
                    data_in_last       <= m_rdata;
                    data_in_last_valid <= 1'b1;
                    read_complete      <= 1'b1;
                    chkr_pass          <= {1'b1, ~rd_err_nxt};
                end else begin
                    beat <= beat + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mm_traffic_gen.sv
// Randomized self-checking bench for mm_traffic_gen acting as AXI4 slave,
// with a pattern/error reference model computed from the burst rules.
module tb_mm_traffic_gen;
    import mm_tg_pkg::*;

    localparam int          DATA_W = 64;
    localparam logic [31:0] SEED   = 32'hA5A5_0000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_wr_start = 1'b0, i_rd_start = 1'b0;
    logic [7:0]          i_len = '0;
    logic [1:0]          i_burst = '0;
    logic [2:0]          i_size = '0;
    logic [31:0]         i_addr = '0;
    logic [31:0]         m_awaddr, m_araddr;
    logic [7:0]          m_awlen, m_arlen;
    logic [2:0]          m_awsize, m_arsize;
    logic [1:0]          m_awburst, m_arburst;
    logic                m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready;
    logic                m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic [1:0]          m_bresp = '0, m_rresp = '0;
    logic [DATA_W-1:0]   m_rdata = '0;
    logic                m_rlast = 1'b0, m_rvalid = 1'b0;
    logic                write_complete, read_complete, o_busy;
    logic [1:0]          chkr_pass;
    logic [DATA_W-1:0]   data_out_first, data_out_last, data_in_first, data_in_last;
    logic                data_out_first_valid, data_out_last_valid, data_in_first_valid, data_in_last_valid;

    int checks = 0;
    int failures = 0;

    mm_traffic_gen #(.DATA_W(DATA_W), .PATTERN_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .i_wr_start(i_wr_start), .i_rd_start(i_rd_start),
        .i_len(i_len), .i_burst(i_burst), .i_size(i_size), .i_addr(i_addr),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .write_complete(write_complete), .read_complete(read_complete), .chkr_pass(chkr_pass),
        .data_out_first(data_out_first), .data_out_first_valid(data_out_first_valid),
        .data_out_last(data_out_last), .data_out_last_valid(data_out_last_valid),
        .data_in_first(data_in_first), .data_in_first_valid(data_in_first_valid),
        .data_in_last(data_in_last), .data_in_last_valid(data_in_last_valid),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts and captures of the 1-cycle valid strobes and chkr_pass[1] rises.
    int cyc = 0, n_of = 0, n_ol = 0, n_if = 0, n_il = 0, n_rise = 0;
    int t_of = 0, t_ol = 0, t_if = 0, t_il = 0;
    logic [DATA_W-1:0] cap_of = '0, cap_ol = '0, cap_if = '0, cap_il = '0;
    logic pass_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (data_out_first_valid) begin n_of++; cap_of = data_out_first; t_of = cyc; end
        if (data_out_last_valid)  begin n_ol++; cap_ol = data_out_last;  t_ol = cyc; end
        if (data_in_first_valid)  begin n_if++; cap_if = data_in_first;  t_if = cyc; end
        if (data_in_last_valid)   begin n_il++; cap_il = data_in_last;   t_il = cyc; end
        if (chkr_pass[1] && !pass_prev) n_rise++;
        pass_prev = chkr_pass[1];
    end

    function automatic logic [DATA_W-1:0] exp_beat(input int k);
        logic [DATA_W-1:0] v;
        for (int j = 0; j < DATA_W/32; j++) v[32*j +: 32] = SEED + 32'(k * (DATA_W/32) + j);
        return v;
    endfunction

    task automatic do_write(input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                            input logic [31:0] addr, input bit stall, input bit both,
                            input bit busy_poke, input bit abort);
        int k, guard, lenv, of0, ol0;
        bit wr;
        lenv = int'(len);
        of0 = n_of; ol0 = n_ol;
        @(negedge clk);
        i_wr_start = 1'b1; i_rd_start = both; i_len = len; i_burst = burst; i_size = size; i_addr = addr;
        @(negedge clk);
        i_wr_start = 1'b0; i_rd_start = 1'b0;
        checks++;
        if (write_complete !== 1'b0) begin failures++; $display("FAIL wc_clear got=%b exp=0", write_complete); end
        guard = 0;
        while (m_awvalid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 20) begin failures++; $display("FAIL aw_timeout awvalid never seen"); return; end
        checks++;
        if ({m_awaddr, m_awlen, m_awsize, m_awburst} !== {addr, len, size, burst}) begin
            failures++;
            $display("FAIL aw_fields got=%h/%h/%h/%h exp=%h/%h/%h/%h", m_awaddr, m_awlen, m_awsize, m_awburst, addr, len, size, burst);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b100) begin
            failures++; $display("FAIL aw_order aw/w/ar got=%b%b%b exp=100", m_awvalid, m_wvalid, m_arvalid);
        end
        m_awready = 1'b1;
        @(negedge clk);
        m_awready = 1'b0;
        k = 0; guard = 0;
        while (k <= lenv && guard < 4000) begin
            guard++;
            checks++;
            if (m_wvalid !== 1'b1 || m_wdata !== exp_beat(k) || m_wlast !== (k == lenv) || m_wstrb !== '1) begin
                failures++;
                $display("FAIL wbeat k=%0d got v=%b d=%h l=%b s=%h exp v=1 d=%h l=%b", k, m_wvalid, m_wdata, m_wlast, m_wstrb, exp_beat(k), (k == lenv));
            end
            if (abort && k == 1) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready, write_complete, read_complete,
                     chkr_pass, o_busy, data_out_first_valid, data_out_last_valid, data_in_first_valid,
                     data_in_last_valid} !== '0 || m_wdata !== '0) begin
                    failures++;
                    $display("FAIL reset_mid got aw=%b w=%b b=%b wc=%b rc=%b cp=%b busy=%b exp all 0", m_awvalid, m_wvalid, m_bready, write_complete, read_complete, chkr_pass, o_busy);
                end
                m_wready = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            wr = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            m_wready = wr;
            if (busy_poke && k == 1) begin i_rd_start = 1'b1; i_wr_start = 1'b1; end
            @(negedge clk);
            i_rd_start = 1'b0; i_wr_start = 1'b0;
            if (wr) k++;
        end
        m_wready = 1'b0;
        checks++;
        if (guard >= 4000) begin failures++; $display("FAIL w_timeout beats=%0d exp=%0d", k, lenv + 1); return; end
        checks++;
        if (m_wvalid !== 1'b0 || m_bready !== 1'b1) begin
            failures++; $display("FAIL w_end got wvalid=%b bready=%b exp 0/1", m_wvalid, m_bready);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checks++;
        if (write_complete !== 1'b0) begin failures++; $display("FAIL wc_early got=%b exp=0", write_complete); end
        m_bresp = 2'($urandom_range(0, 3)); m_bvalid = 1'b1;
        @(negedge clk);
        m_bvalid = 1'b0; m_bresp = '0;
        checks++;
        if ({write_complete, o_busy, m_bready} !== 3'b100) begin
            failures++; $display("FAIL wc_done got wc/busy/bready=%b%b%b exp=100", write_complete, o_busy, m_bready);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (n_of - of0 != 1 || n_ol - ol0 != 1 || cap_of !== exp_beat(0) || cap_ol !== exp_beat(lenv)) begin
            failures++;
            $display("FAIL wcap nf=%0d nl=%0d first=%h last=%h exp 1 1 %h %h", n_of - of0, n_ol - ol0, cap_of, cap_ol, exp_beat(0), exp_beat(lenv));
        end
        if (lenv == 0) begin
            checks++;
            if (t_of != t_ol) begin failures++; $display("FAIL wlen0_same_cycle got first=%0d last=%0d", t_of, t_ol); end
        end
        checks++;
        if (m_arvalid !== 1'b0 || o_busy !== 1'b0) begin
            failures++; $display("FAIL stray_start got arvalid=%b busy=%b exp 0/0", m_arvalid, o_busy);
        end
    endtask

    task automatic do_read(input logic [7:0] len, input logic [1:0] burst, input logic [31:0] addr,
                           input int corrupt_k, input int slverr_k, input bit drop_rlast, input bit stall);
        int k, guard, lenv, if0, il0, pr0, bit_idx;
        bit exp_err, go;
        logic [DATA_W-1:0] d, first_d, last_d;
        lenv = int'(len);
        if0 = n_if; il0 = n_il; pr0 = n_rise;
        exp_err = 1'b0; first_d = '0; last_d = '0;
        @(negedge clk);
        i_rd_start = 1'b1; i_len = len; i_burst = burst; i_size = 3'd3; i_addr = addr;
        @(negedge clk);
        i_rd_start = 1'b0;
        checks++;
        if (read_complete !== 1'b0 || chkr_pass !== 2'b00) begin
            failures++; $display("FAIL rd_clear got rc=%b cp=%b exp 0/00", read_complete, chkr_pass);
        end
        checks++;
        if (m_arvalid !== 1'b1 || m_awvalid !== 1'b0 || {m_araddr, m_arlen, m_arburst} !== {addr, len, burst}) begin
            failures++; $display("FAIL ar_fields got v=%b a=%h l=%h b=%h exp 1 %h %h %h", m_arvalid, m_araddr, m_arlen, m_arburst, addr, len, burst);
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        k = 0; guard = 0;
        while (k <= lenv && guard < 4000) begin
            guard++;
            checks++;
            if (m_rready !== 1'b1) begin failures++; $display("FAIL rready k=%0d got=%b exp=1", k, m_rready); end
            go = !(stall && $urandom_range(0, 1) == 0);
            m_rvalid = go; m_rlast = 1'b0; m_rresp = AXI_RESP_OKAY;
            if (go) begin
                d = exp_beat(k);
                if (k == corrupt_k) begin bit_idx = $urandom_range(0, DATA_W - 1); d[bit_idx] = ~d[bit_idx]; exp_err = 1'b1; end
                if (k == slverr_k) begin m_rresp = 2'b10; exp_err = 1'b1; end
                m_rlast = (k == lenv) && !drop_rlast;
                if (k == lenv && drop_rlast) exp_err = 1'b1;
                m_rdata = d;
                if (k == 0) first_d = d;
                last_d = d;
            end
            @(negedge clk);
            if (go) k++;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = '0;
        checks++;
        if (guard >= 4000) begin failures++; $display("FAIL r_timeout beats=%0d", k); return; end
        checks++;
        if (read_complete !== 1'b1 || chkr_pass !== {1'b1, ~exp_err} || o_busy !== 1'b0 || m_rready !== 1'b0) begin
            failures++;
            $display("FAIL rd_done got rc=%b cp=%b busy=%b rready=%b exp 1 %b 0 0", read_complete, chkr_pass, o_busy, m_rready, {1'b1, ~exp_err});
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (n_if - if0 != 1 || n_il - il0 != 1 || cap_if !== first_d || cap_il !== last_d || n_rise - pr0 != 1) begin
            failures++;
            $display("FAIL rcap nf=%0d nl=%0d rises=%0d first=%h last=%h exp 1 1 1 %h %h", n_if - if0, n_il - il0, n_rise - pr0, cap_if, cap_il, first_d, last_d);
        end
        if (lenv == 0) begin
            checks++;
            if (t_if != t_il) begin failures++; $display("FAIL rlen0_same_cycle got first=%0d last=%0d", t_if, t_il); end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, write_complete, read_complete, chkr_pass,
             o_busy, data_out_first_valid, data_in_first_valid} !== '0 || m_awaddr !== '0 || m_wdata !== '0) begin
            failures++; $display("FAIL reset_state got wc=%b rc=%b cp=%b busy=%b aw=%b exp all 0", write_complete, read_complete, chkr_pass, o_busy, m_awvalid);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        do_write(8'd3, BURST_INCR, 3'd3, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cap_of[31:0] !== 32'hA5A5_0000) begin failures++; $display("FAIL first_word got=%h exp=a5a50000", cap_of[31:0]); end
        do_read(8'd3, BURST_INCR, 32'h100, -1, -1, 1'b0, 1'b0);
        checks++;
        if (cap_il[31:0] !== 32'hA5A5_0006) begin failures++; $display("FAIL last_word got=%h exp=a5a50006", cap_il[31:0]); end
    endtask

    task automatic test_read_errors;
        do_read(8'd3, BURST_INCR, 32'h100, 2, -1, 1'b0, 1'b0);
        do_read(8'd3, BURST_INCR, 32'h100, -1, 1, 1'b0, 1'b0);
        do_read(8'd4, BURST_WRAP, 32'h200, -1, -1, 1'b1, 1'b0);
        do_read(8'd2, BURST_FIXED, 32'h300, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_len0;
        do_write(8'd0, BURST_FIXED, 3'd2, 32'hDEAD_BEE0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_read(8'd0, BURST_FIXED, 32'hDEAD_BEE0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall_long;
        do_write(8'd255, BURST_INCR, 3'd3, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_read(8'd255, BURST_INCR, 32'h1000, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [7:0] len;
        logic [31:0] addr;
        logic [1:0] burst;
        for (int i = 0; i < 4; i++) begin
            len = 8'($urandom_range(0, 20));
            addr = $urandom;
            burst = 2'($urandom_range(0, 2));
            do_write(len, burst, 3'($urandom_range(0, 3)), addr, 1'b1, 1'b0, 1'b0, 1'b0);
            do_read(len, burst, addr, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(len))) : -1,
                    -1, 1'b0, 1'b1);
        end
    endtask

    task automatic test_simultaneous;
        do_write(8'd2, BURST_INCR, 3'd3, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_busy_start;
        do_write(8'd3, BURST_INCR, 3'd3, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        do_write(8'd3, BURST_INCR, 3'd3, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1);
        do_write(8'd3, BURST_INCR, 3'd3, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read_errors();
        test_len0();
        test_stall_long();
        test_random();
        test_simultaneous();
        test_busy_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
